// File: rtl/multiplication_dispatcher_pkg.sv
// rtl/multiplication_dispatcher_pkg.sv - shared defaults and types for the multiplication dispatcher
package multiplication_dispatcher_pkg;

    localparam int DISPATCH_WIDTH   = 8;
    localparam int DISPATCH_DEPTH   = 4;
    localparam int DISPATCH_TIMEOUT = 64;

    typedef struct packed {
        logic [DISPATCH_WIDTH-1:0] multiplicand;
        logic [DISPATCH_WIDTH-1:0] multiplier;
    } operand_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/multiplication_dispatcher_if.sv
// rtl/multiplication_dispatcher_if.sv - request and result streams of the multiplication dispatcher
interface multiplication_dispatcher_if
    import multiplication_dispatcher_pkg::*;
#(
    parameter int WIDTH = DISPATCH_WIDTH
);
    logic               req_valid_in;
    logic               req_ready_out;
    logic [WIDTH-1:0]   req_multiplicand_in;
    logic [WIDTH-1:0]   req_multiplier_in;
    logic               res_valid_out;
    logic               res_ready_in;
    logic [2*WIDTH-1:0] res_product_out;
    logic               res_overflow_out;
    logic               res_timeout_out;

    modport master (
        output req_valid_in, req_multiplicand_in, req_multiplier_in, res_ready_in,
        input  req_ready_out, res_valid_out, res_product_out, res_overflow_out, res_timeout_out
    );

    modport slave (
        input  req_valid_in, req_multiplicand_in, req_multiplier_in, res_ready_in,
        output req_ready_out, res_valid_out, res_product_out, res_overflow_out, res_timeout_out
    );
endinterface

// File: rtl/multiplication_dispatcher_operand_fifo.sv
// rtl/multiplication_dispatcher_operand_fifo.sv - operand pair FIFO with occupancy count
module multiplication_dispatcher_operand_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset_in,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == COUNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/multiplication_dispatcher.sv
// rtl/multiplication_dispatcher.sv - queues operand pairs and drives a start/done multiplicator
module multiplication_dispatcher
    import multiplication_dispatcher_pkg::*;
#(
    parameter int WIDTH   = DISPATCH_WIDTH,
    parameter int DEPTH   = DISPATCH_DEPTH,
    parameter int TIMEOUT = DISPATCH_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset_in,
    multiplication_dispatcher_if.slave stream,
    output logic [WIDTH-1:0]           multiplicand_out,
    output logic [WIDTH-1:0]           multiplier_out,
    output logic                       start_out,
    input  logic                       done_in,
    input  logic [2*WIDTH-1:0]         product_in,
    input  logic                       overflow_in,
    output logic [$clog2(DEPTH+1)-1:0] pending_count_out,
    output logic                       busy_out
);
    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    dispatch_state_t    state;
    dispatch_state_t    next_state;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [TIMER_W-1:0] timer;
    logic               done_q;
    logic               done_edge;
    logic               slot_free;
    logic               capture_done;
    logic               capture_timeout;
    logic               res_valid;
    logic [2*WIDTH-1:0] res_product;
    logic               res_overflow;
    logic               res_timeout;

    // Ready is masked during reset so every output reads 0 while reset_in is high.
    assign stream.req_ready_out    = !reset_in && !fifo_full;
    assign fifo_push               = stream.req_valid_in && stream.req_ready_out;
    assign stream.res_valid_out    = res_valid;
    assign stream.res_product_out  = res_product;
    assign stream.res_overflow_out = res_overflow;
    assign stream.res_timeout_out  = res_timeout;

    assign done_edge = done_in && !done_q;
    assign slot_free = !res_valid || stream.res_ready_in;
    assign start_out = (state == ISSUE);
    assign busy_out  = (state != IDLE);

    multiplication_dispatcher_operand_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_in  (reset_in),
        .push      (fifo_push),
        .push_data ({stream.req_multiplicand_in, stream.req_multiplier_in}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending_count_out)
    );

    always_comb begin
        next_state      = state;
        fifo_pop        = 1'b0;
        capture_done    = 1'b0;
        capture_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (slot_free) begin
                        fifo_pop   = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                // A done edge in the final timer cycle still counts as a completion.
                if (done_edge) begin
                    capture_done = 1'b1;
                    next_state   = IDLE;
                end else if (timer == TIMER_LAST) begin
                    capture_timeout = 1'b1;
                    next_state      = IDLE;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    fifo_pop   = 1'b1;
                    next_state = ISSUE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state            <= IDLE;
            timer            <= '0;
            done_q           <= 1'b0;
            multiplicand_out <= '0;
            multiplier_out   <= '0;
            res_valid        <= 1'b0;
            res_product      <= '0;
            res_overflow     <= 1'b0;
            res_timeout      <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= done_in;
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT && timer != TIMER_LAST) begin
                timer <= timer + 1'b1;
            end
            if (fifo_pop) begin
                {multiplicand_out, multiplier_out} <= fifo_head;
            end
            // A fresh capture overrides a same-cycle consume of the previous result.
            if (capture_done) begin
                res_valid    <= 1'b1;
                res_product  <= product_in;
                res_overflow <= overflow_in;
                res_timeout  <= 1'b0;
            end else if (capture_timeout) begin
                res_valid    <= 1'b1;
                res_product  <= '0;
                res_overflow <= 1'b0;
                res_timeout  <= 1'b1;
            end else if (res_valid && stream.res_ready_in) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiplication_dispatcher.sv
// tb/tb_multiplication_dispatcher.sv - randomized self-checking bench with a multiplicator model
module tb_multiplication_dispatcher;
    import multiplication_dispatcher_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset_in;
    always #5 clock = ~clock;

    multiplication_dispatcher_if #(.WIDTH(W)) bus ();

    logic [W-1:0]            multiplicand_out;
    logic [W-1:0]            multiplier_out;
    logic                    start_out;
    logic                    done_in;
    logic [2*W-1:0]          product_in;
    logic                    overflow_in;
    logic [$clog2(D+1)-1:0]  pending_count_out;
    logic                    busy_out;

    multiplication_dispatcher #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clock             (clock),
        .reset_in          (reset_in),
        .stream            (bus.slave),
        .multiplicand_out  (multiplicand_out),
        .multiplier_out    (multiplier_out),
        .start_out         (start_out),
        .done_in           (done_in),
        .product_in        (product_in),
        .overflow_in       (overflow_in),
        .pending_count_out (pending_count_out),
        .busy_out          (busy_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: every accepted pair yields one result, in order, equal to a*b.
    typedef struct {
        operand_pair_t ops;
        bit            to;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [2*W-1:0] mon_p;
    int             res_count   = 0;
    int             start_count = 0;

    bit hang       = 1'b0;
    bit hold_done  = 1'b0;
    bit rand_delay = 1'b0;
    bit rand_ready = 1'b0;
    int fixed_delay = 8;
    int stale_len   = 6;

    always @(negedge clock) begin
        if (reset_in) begin
            exp_q.delete();
        end else begin
            if (start_out) start_count++;
            if (bus.req_valid_in && bus.req_ready_out) begin
                mon_e.ops.multiplicand = bus.req_multiplicand_in;
                mon_e.ops.multiplier   = bus.req_multiplier_in;
                mon_e.to               = hang;
                exp_q.push_back(mon_e);
            end
            if (bus.res_valid_out && bus.res_ready_in) begin
                res_count++;
                if (exp_q.size() == 0) begin
                    expect_eq("res_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_p = mon_e.to ? '0 : (2*W)'(mon_e.ops.multiplicand) * (2*W)'(mon_e.ops.multiplier);
                    expect_eq("res_product", 32'(bus.res_product_out), 32'(mon_p));
                    expect_eq("res_overflow", 32'(bus.res_overflow_out), 32'((mon_p >> W) != 0));
                    expect_eq("res_timeout", 32'(bus.res_timeout_out), 32'(mon_e.to));
                end
            end
        end
    end

    // Multiplicator model: done_in rises a delay after start; optional hang and held-done modes.
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [2*W-1:0] m_p;
    int             m_cnt;
    int             m_stale;
    bit             m_busy;

    initial begin
        done_in = 1'b0; product_in = '0; overflow_in = 1'b0; m_busy = 1'b0;
        m_cnt = 0; m_stale = 0;
        forever begin
            @(posedge clock); #1;
            if (reset_in) begin
                m_busy = 1'b0; done_in = 1'b0; product_in = '0; overflow_in = 1'b0;
            end else if (start_out) begin
                m_a = multiplicand_out; m_b = multiplier_out; m_busy = 1'b1;
                m_cnt   = rand_delay ? int'($urandom_range(1, 12)) : fixed_delay;
                m_stale = hold_done ? stale_len : 0;
                if (!hold_done) done_in = 1'b0;
            end else if (m_busy && hang) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_stale > 0) begin
                    m_stale--;
                    if (m_stale == 0) done_in = 1'b0;
                end else if (m_cnt > 1) begin
                    m_cnt--;
                end else begin
                    m_p = (2*W)'(m_a) * (2*W)'(m_b);
                    product_in = m_p; overflow_in = ((m_p >> W) != 0); done_in = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (!hold_done) begin
                done_in = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
        if (rand_ready) bus.res_ready_in = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int bound, output bit ok);
        bus.req_valid_in = 1'b1; bus.req_multiplicand_in = a; bus.req_multiplier_in = b;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.req_ready_out) ok = 1'b1;
            tick();
            if (ok) break;
        end
        bus.req_valid_in = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int n);
        n = 0;
        while (!start_out && n < bound) begin tick(); n++; end
        expect_eq("start_seen", 32'(start_out), 32'd1);
    endtask

    task automatic wait_res(input int bound, output int n);
        n = 0;
        while (!bus.res_valid_out && n < bound) begin tick(); n++; end
        expect_eq("res_seen", 32'(bus.res_valid_out), 32'd1);
    endtask

    task automatic consume();
        bus.res_ready_in = 1'b1; tick(); bus.res_ready_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    bit ok;
    int n, sc, rc, bad, acc;

    initial begin
        reset_in = 1'b1;
        bus.req_valid_in = 1'b0; bus.req_multiplicand_in = '0; bus.req_multiplier_in = '0;
        bus.res_ready_in = 1'b0;
        #2;
        expect_eq("rst_start", 32'(start_out), 32'd0);
        expect_eq("rst_res_valid", 32'(bus.res_valid_out), 32'd0);
        expect_eq("rst_pending", 32'(pending_count_out), 32'd0);
        expect_eq("rst_busy", 32'(busy_out), 32'd0);
        expect_eq("rst_req_ready", 32'(bus.req_ready_out), 32'd0);
        expect_eq("rst_operand", 32'(multiplicand_out), 32'd0);
        tick(); tick();
        reset_in = 1'b0;
        #1;
        expect_eq("post_rst_ready", 32'(bus.req_ready_out), 32'd1);

        // 12 x 13 with latency and single start pulse
        sc = start_count;
        push(8'd12, 8'd13, 10, ok);
        expect_eq("t1_accept", 32'(ok), 32'd1);
        expect_eq("t1_no_start_yet", 32'(start_out), 32'd0);
        expect_eq("t1_pending", 32'(pending_count_out), 32'd1);
        tick();
        expect_eq("t1_start", 32'(start_out), 32'd1);
        expect_eq("t1_busy", 32'(busy_out), 32'd1);
        wait_res(60, n);
        expect_eq("t1_latency", 32'(n), 32'(fixed_delay + 1));
        expect_eq("t1_product", 32'(bus.res_product_out), 32'd156);
        expect_eq("t1_overflow", 32'(bus.res_overflow_out), 32'd0);
        expect_eq("t1_timeout", 32'(bus.res_timeout_out), 32'd0);
        expect_eq("t1_start_pulses", 32'(start_count - sc), 32'd1);
        consume();
        expect_eq("t1_res_cleared", 32'(bus.res_valid_out), 32'd0);

        // 255 x 255 overflows the operand width
        push(8'd255, 8'd255, 10, ok);
        wait_res(60, n);
        expect_eq("t2_product", 32'(bus.res_product_out), 32'h0000FE01);
        expect_eq("t2_overflow", 32'(bus.res_overflow_out), 32'd1);
        consume();

        // fill the FIFO while the result slot is blocked
        sc = start_count; acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 3), 8'(2 * i + 1), 20, ok);
            if (ok) acc++;
        end
        expect_eq("t3_accepted", 32'(acc), 32'd5);
        expect_eq("t3_sixth_stalled", 32'(ok), 32'd0);
        expect_eq("t3_pending", 32'(pending_count_out), 32'd4);
        expect_eq("t3_req_ready", 32'(bus.req_ready_out), 32'd0);
        expect_eq("t3_res_valid", 32'(bus.res_valid_out), 32'd1);
        expect_eq("t3_busy_hold", 32'(busy_out), 32'd1);
        expect_eq("t3_one_in_flight", 32'(start_count - sc), 32'd1);

        rc = res_count;
        bus.res_ready_in = 1'b1;
        n = 0;
        while (res_count - rc < 5 && n < 400) begin tick(); n++; end
        repeat (20) tick();
        bus.res_ready_in = 1'b0;
        expect_eq("t4_results", 32'(res_count - rc), 32'd5);
        expect_eq("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        expect_eq("t4_pending", 32'(pending_count_out), 32'd0);

        // watchdog on a hung multiplicator
        hang = 1'b1;
        push(8'd3, 8'd5, 10, ok);
        wait_start(10, n);
        wait_res(60, n);
        expect_eq("t5_timeout_latency", 32'(n), 32'(TO + 1));
        expect_eq("t5_timeout_flag", 32'(bus.res_timeout_out), 32'd1);
        expect_eq("t5_timeout_product", 32'(bus.res_product_out), 32'd0);
        expect_eq("t5_timeout_overflow", 32'(bus.res_overflow_out), 32'd0);
        consume();
        hang = 1'b0;
        push(8'd10, 8'd11, 10, ok);
        wait_res(60, n);
        expect_eq("t5_recover_product", 32'(bus.res_product_out), 32'd110);
        expect_eq("t5_recover_flag", 32'(bus.res_timeout_out), 32'd0);
        consume();

        // reset in the middle of WAIT with requests pending
        hang = 1'b1; bus.res_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(i + 1), 8'd2, 10, ok);
        repeat (3) tick();
        expect_eq("t6_pending_before", 32'(pending_count_out), 32'd3);
        expect_eq("t6_busy_before", 32'(busy_out), 32'd1);
        reset_in = 1'b1;
        #1;
        expect_eq("t6_rst_start", 32'(start_out), 32'd0);
        expect_eq("t6_rst_res_valid", 32'(bus.res_valid_out), 32'd0);
        expect_eq("t6_rst_pending", 32'(pending_count_out), 32'd0);
        expect_eq("t6_rst_busy", 32'(busy_out), 32'd0);
        tick(); tick();
        reset_in = 1'b0; hang = 1'b0; bus.res_ready_in = 1'b0;
        tick();
        push(8'd7, 8'd9, 10, ok);
        wait_res(60, n);
        expect_eq("t6_product", 32'(bus.res_product_out), 32'd63);
        consume();

        // done_in held high from the previous operation
        hold_done = 1'b1; bus.res_ready_in = 1'b1;
        push(8'd2, 8'd3, 10, ok);
        wait_res(60, n);
        expect_eq("t7_first_product", 32'(bus.res_product_out), 32'd6);
        tick();
        push(8'd4, 8'd5, 10, ok);
        wait_start(10, n);
        bad = 0;
        for (int i = 0; i < stale_len; i++) begin
            tick();
            if (bus.res_valid_out) bad++;
        end
        expect_eq("t7_stale_done_ignored", 32'(bad), 32'd0);
        wait_res(60, n);
        expect_eq("t7_second_product", 32'(bus.res_product_out), 32'd20);
        tick(); tick();
        hold_done = 1'b0; bus.res_ready_in = 1'b0;
        tick();

        // randomized traffic against the reference queue
        rand_delay = 1'b1; rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            push(8'($urandom), 8'($urandom), 300, ok);
            expect_eq("rand_push_ok", 32'(ok), 32'd1);
        end
        n = 0;
        while ((exp_q.size() != 0 || busy_out) && n < 3000) begin tick(); n++; end
        expect_eq("rand_drained", 32'(exp_q.size()), 32'd0);
        rand_ready = 1'b0; rand_delay = 1'b0; bus.res_ready_in = 1'b0;
        tick();
        expect_eq("rand_idle", 32'(busy_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplication_dispatcher.md
Name: multiplication_dispatcher

Overview:
Upstream feeder for the sequential multiplicator. It buffers operand pairs from a valid/ready request stream in a small FIFO and issues one start pulse per pair. It waits for the multiplicator's done, captures product and overflow, and presents each result on a valid/ready result stream. It serialises back-to-back requests onto the single-shot start/done protocol and watchdogs a hung multiplicator.

Parameters:
WIDTH, 8, operand width; must match the multiplicator's WIDTH.
DEPTH, 4, request FIFO entries; power of two, at least 2.
TIMEOUT, 64, maximum cycles spent in WAIT before the operation is abandoned.

Ports:
clock  in  1  single system clock, rising edge
reset_in  in  1  asynchronous, active-high reset
req_valid_in  in  1  request present
req_ready_out  out  1  FIFO can accept
req_multiplicand_in  in  WIDTH  request multiplicand
req_multiplier_in  in  WIDTH  request multiplier
multiplicand_out  out  WIDTH  to multiplicator multiplicand_in
multiplier_out  out  WIDTH  to multiplicator multiplier_in
start_out  out  1  one-cycle start pulse to multiplicator start_in
done_in  in  1  from multiplicator done_out
product_in  in  2*WIDTH  from multiplicator product_out
overflow_in  in  1  from multiplicator overflow_out
res_valid_out  out  1  result held
res_ready_in  in  1  consumer accepts result
res_product_out  out  2*WIDTH  captured product
res_overflow_out  out  1  captured overflow
res_timeout_out  out  1  result is a watchdog abort
pending_count_out  out  $clog2(DEPTH+1)  FIFO occupancy
busy_out  out  1  FSM not in IDLE

Behaviour:
- Reset: async on reset_in high; all outputs 0; FIFO empty; FSM IDLE; timer 0. The multiplicator shares reset_in.
- Push: req_valid_in && req_ready_out at a rising edge; req_ready_out = !full (registered occupancy, no bypass).
- Pop and push in the same cycle are both allowed; occupancy is unchanged.
- Full FIFO: push is refused and the request holds. Empty FIFO: no pop.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE -> ISSUE when the FIFO is non-empty and the result slot is free (res_valid_out=0, or res_valid_out && res_ready_in this cycle). The pop loads multiplicand_out and multiplier_out.
- ISSUE: start_out=1 for exactly this cycle; -> WAIT; timer cleared.
- WAIT: a rising edge of done_in (registered done_q=0, done_in=1) captures product_in and overflow_in into the result register. It sets res_valid_out=1 and res_timeout_out=0, then -> IDLE.
- A level-high done_in carried over from a previous operation must not complete the current one.
- WAIT timeout: timer reaches TIMEOUT-1 without a done edge -> res_valid_out=1, res_product_out=0, res_overflow_out=0, res_timeout_out=1; -> IDLE.
- HOLD: reserved. Entered from IDLE only if the slot is occupied and the FIFO is non-empty; exits to ISSUE on res_ready_in.
- Operand outputs remain stable from ISSUE until the next pop.
- Result register: cleared (res_valid_out=0) on res_valid_out && res_ready_in unless a new capture occurs in the same cycle.
- Capture and consume in the same cycle: new data wins and res_valid_out stays 1.
- Latency: accept at edge N, pop at N+1, start_out high in cycle N+1..N+2.
- res_valid_out rises one edge after the done_in rising edge is sampled.
- Back-to-back: the next start_out comes at minimum 2 cycles after capture.
- Widths: product is 2*WIDTH and passed through unmodified; the dispatcher performs no arithmetic.
- Timer width is $clog2(TIMEOUT); it saturates and never wraps.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package sequential_multiplicator_tb_pkg / rtl package: WIDTH, DEPTH, TIMEOUT defaults; typedef operand_pair_t (packed {multiplicand, multiplier}); typedef enum dispatch_state_t {IDLE, ISSUE, WAIT, HOLD}.
- One natural sub-module: operand_fifo (DEPTH x 2*WIDTH, push/pop/full/empty/count).

Test Plan:
1. Push 12x13; model asserts done 8 cycles after start -> single start_out pulse; res_product_out=156, res_overflow_out=0, res_timeout_out=0.
2. Push 255x255; model returns product 65025, overflow 1 -> res_product_out=16'hFE01, res_overflow_out=1.
3. res_ready_in=0, push 6 pairs back-to-back -> first in flight, 4 buffered, pending_count_out=4, req_ready_out=0, sixth stalls.
4. Test 3 continued: release res_ready_in -> exactly 5 results in order with correct products.
5. Model never raises done_in, TIMEOUT=16 -> after 16 WAIT cycles res_valid_out=1, res_timeout_out=1, res_product_out=0; next request proceeds normally.
6. Assert reset_in mid-WAIT with 3 pending -> same cycle: start_out=0, res_valid_out=0, pending_count_out=0, busy_out=0; afterwards push 7x9 -> res_product_out=63.
7. Hold done_in high across two operations -> second operation completes only on a fresh done rising edge.
